decode_stage: RTL

Second pipeline stage of the RV32I core. Takes the aligned 32-bit instruction and PC from the fetch stage and decodes them into a registered bundle for the execute stage: register addresses, immediate, ALU operation, opcode class and exception flags. Also detects load-use hazards against the execute stage. Owns the decode/execute pipeline register and propagates the shared clock-enable, stall and flush protocol.

---
 rtl/decode_stage.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode and decode/execute pipeline register.
// The instruction is decoded combinationally into a one-hot bundle and
// registered for the execute stage. The stage also detects load-use hazards
// against the instruction currently in execute.
//
// One-hot bit order (bit 0 first):
//   o_alu_op    : ADD SUB SLT SLTU XOR OR AND SLL SRL SRA EQ NEQ GE GEU
//   o_opcode    : RTYPE ITYPE LOAD STORE BRANCH JAL JALR LUI AUIPC SYSTEM FENCE
//   o_exception : ILLEGAL ECALL EBREAK MRET
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_ce,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_ex_ce,
    input  logic            i_ex_is_load,
    input  logic [4:0]      i_ex_rd_addr,
    output logic            o_stall,
    output logic            o_ce,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    output logic [4:0]      o_rd_addr,
    output logic            o_rs1_used,
    output logic            o_rs2_used,
    output logic [2:0]      o_funct3,
    output logic [XLEN-1:0] o_imm,
    output logic [13:0]     o_alu_op,
    output logic [10:0]     o_opcode,
    output logic [3:0]      o_exception
);

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_AND  = 6;
    localparam int ALU_SLL  = 7;
    localparam int ALU_SRL  = 8;
    localparam int ALU_SRA  = 9;
    localparam int ALU_EQ   = 10;
    localparam int ALU_NEQ  = 11;
    localparam int ALU_GE   = 12;
    localparam int ALU_GEU  = 13;

    localparam int OPC_RTYPE  = 0;
    localparam int OPC_ITYPE  = 1;
    localparam int OPC_LOAD   = 2;
    localparam int OPC_STORE  = 3;
    localparam int OPC_BRANCH = 4;
    localparam int OPC_JAL    = 5;
    localparam int OPC_JALR   = 6;
    localparam int OPC_LUI    = 7;
    localparam int OPC_AUIPC  = 8;
    localparam int OPC_SYSTEM = 9;
    localparam int OPC_FENCE  = 10;

    localparam int EXC_ILLEGAL = 0;
    localparam int EXC_ECALL   = 1;
    localparam int EXC_EBREAK  = 2;
    localparam int EXC_MRET    = 3;

    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [10:0]     cls;
    logic [3:0]      exc;
    logic [13:0]     alu;
    logic [XLEN-1:0] imm;
    logic            rs1_used;
    logic            rs2_used;
    logic            stall_bit;

    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign rd     = i_instr[11:7];

    // Opcode class and exception decode; an illegal encoding leaves the class empty.
    always_comb begin
        cls = '0;
        exc = '0;
        if (i_instr[1:0] != 2'b11) begin
            exc[EXC_ILLEGAL] = 1'b1;
        end else begin
            case (i_instr[6:2])
                5'b01100: begin
                    if (funct7 == 7'h00 ||
                        (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
                        cls[OPC_RTYPE] = 1'b1;
                    else
                        exc[EXC_ILLEGAL] = 1'b1;
                end
                5'b00100: cls[OPC_ITYPE]  = 1'b1;
                5'b00000: cls[OPC_LOAD]   = 1'b1;
                5'b01000: cls[OPC_STORE]  = 1'b1;
                5'b11000: cls[OPC_BRANCH] = 1'b1;
                5'b11011: cls[OPC_JAL]    = 1'b1;
                5'b11001: cls[OPC_JALR]   = 1'b1;
                5'b01101: cls[OPC_LUI]    = 1'b1;
                5'b00101: cls[OPC_AUIPC]  = 1'b1;
                5'b00011: cls[OPC_FENCE]  = 1'b1;
                5'b11100: begin
                    // funct3 != 0 is a CSR access and decodes as plain SYSTEM
                    if (funct3 != 3'b000) begin
                        cls[OPC_SYSTEM] = 1'b1;
                    end else if (i_instr[19:7] != 13'd0) begin
                        exc[EXC_ILLEGAL] = 1'b1;
                    end else begin
                        case (i_instr[31:20])
                            12'h000: begin
                                cls[OPC_SYSTEM] = 1'b1;
                                exc[EXC_ECALL]  = 1'b1;
                            end
                            12'h001: begin
                                cls[OPC_SYSTEM] = 1'b1;
                                exc[EXC_EBREAK] = 1'b1;
                            end
                            12'h302: begin
                                cls[OPC_SYSTEM] = 1'b1;
                                exc[EXC_MRET]   = 1'b1;
                            end
                            default: exc[EXC_ILLEGAL] = 1'b1;
                        endcase
                    end
                end
                default: exc[EXC_ILLEGAL] = 1'b1;
            endcase
        end
    end

    // Immediate generation selected by opcode class.
    always_comb begin
        imm = '0;
        if (cls[OPC_ITYPE] | cls[OPC_LOAD] | cls[OPC_JALR])
            imm = {{20{i_instr[31]}}, i_instr[31:20]};
        else if (cls[OPC_STORE])
            imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        else if (cls[OPC_BRANCH])
            imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                   i_instr[11:8], 1'b0};
        else if (cls[OPC_LUI] | cls[OPC_AUIPC])
            imm = {i_instr[31:12], 12'b0};
        else if (cls[OPC_JAL])
            imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                   i_instr[30:21], 1'b0};
    end

    // ALU operation select; SUB exists only for register-register forms.
    always_comb begin
        alu = '0;
        if (cls[OPC_RTYPE] | cls[OPC_ITYPE]) begin
            case (funct3)
                3'b000: begin
                    if (cls[OPC_RTYPE] && funct7[5]) alu[ALU_SUB] = 1'b1;
                    else                             alu[ALU_ADD] = 1'b1;
                end
                3'b001: alu[ALU_SLL]  = 1'b1;
                3'b010: alu[ALU_SLT]  = 1'b1;
                3'b011: alu[ALU_SLTU] = 1'b1;
                3'b100: alu[ALU_XOR]  = 1'b1;
                3'b101: begin
                    if (funct7[5]) alu[ALU_SRA] = 1'b1;
                    else           alu[ALU_SRL] = 1'b1;
                end
                3'b110: alu[ALU_OR]   = 1'b1;
                default: alu[ALU_AND] = 1'b1;
            endcase
        end else if (cls[OPC_BRANCH]) begin
            case (funct3)
                3'b000: alu[ALU_EQ]   = 1'b1;
                3'b001: alu[ALU_NEQ]  = 1'b1;
                3'b100: alu[ALU_SLT]  = 1'b1;
                3'b101: alu[ALU_GE]   = 1'b1;
                3'b110: alu[ALU_SLTU] = 1'b1;
                3'b111: alu[ALU_GEU]  = 1'b1;
                default: alu = '0;
            endcase
        end else if (cls[OPC_LOAD] | cls[OPC_STORE] | cls[OPC_JAL] |
                     cls[OPC_JALR] | cls[OPC_LUI] | cls[OPC_AUIPC]) begin
            alu[ALU_ADD] = 1'b1;
        end
    end

    // Source usage and load-use hazard against the execute stage.
    always_comb begin
        rs1_used  = (|cls) & ~(cls[OPC_LUI] | cls[OPC_AUIPC] | cls[OPC_JAL]);
        rs2_used  = cls[OPC_RTYPE] | cls[OPC_STORE] | cls[OPC_BRANCH];
        o_stall   = i_ce & i_ex_ce & i_ex_is_load & (i_ex_rd_addr != 5'd0) &
                    ((rs1_used & (rs1 == i_ex_rd_addr)) |
                     (rs2_used & (rs2 == i_ex_rd_addr)));
        stall_bit = i_stall | o_stall;
    end

    // Pipeline register: payload loads on an unstalled valid input.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ce        <= 1'b0;
            o_pc        <= '0;
            o_instr     <= '0;
            o_rs1_addr  <= '0;
            o_rs2_addr  <= '0;
            o_rd_addr   <= '0;
            o_rs1_used  <= 1'b0;
            o_rs2_used  <= 1'b0;
            o_funct3    <= '0;
            o_imm       <= '0;
            o_alu_op    <= '0;
            o_opcode    <= '0;
            o_exception <= '0;
        end else begin
            if (i_ce && !stall_bit) begin
                o_pc        <= i_pc;
                o_instr     <= i_instr;
                o_rs1_addr  <= rs1;
                o_rs2_addr  <= rs2;
                o_rd_addr   <= rd;
                o_rs1_used  <= rs1_used;
                o_rs2_used  <= rs2_used;
                o_funct3    <= funct3;
                o_imm       <= imm;
                o_alu_op    <= alu;
                o_opcode    <= cls;
                o_exception <= exc;
            end
            // A decode-only stall turns the execute slot into a bubble;
            // a global stall freezes it instead.
            if (!stall_bit && i_flush)
                o_ce <= 1'b0;
            else if (!stall_bit)
                o_ce <= i_ce;
            else if (!i_stall)
                o_ce <= 1'b0;
        end
    end

endmodule
